// File: rtl/anc_engine_arbiter_if.sv
// Channel and engine signal bundle for the shared ANC engine arbiter.
// The arbiter takes the slave view; the surrounding logic takes the master view.
interface anc_engine_arbiter_if #(
  parameter int NCH = 2,
  parameter int DW  = 16
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_ready;
  logic [NCH*DW-1:0] ch_x;
  logic [NCH*DW-1:0] ch_e;
  logic [NCH*DW-1:0] ch_a;
  logic              eng_go;
  logic [DW-1:0]     eng_x;
  logic [DW-1:0]     eng_e;
  logic [DW-1:0]     eng_a;
  logic [CW-1:0]     eng_ch;
  logic              eng_done;
  logic [DW-1:0]     eng_out;
  logic              res_valid;
  logic [CW-1:0]     res_ch;
  logic [DW-1:0]     res_sample;
  logic              timeout_err;
  logic              err_clr;

  modport slave (
    input  ch_valid, ch_x, ch_e, ch_a,
    input  eng_done, eng_out, err_clr,
    output ch_ready, eng_go,
    output eng_x, eng_e, eng_a, eng_ch,
    output res_valid, res_ch, res_sample,
    output timeout_err
  );

  modport master (
    output ch_valid, ch_x, ch_e, ch_a,
    output eng_done, eng_out, err_clr,
    input  ch_ready, eng_go,
    input  eng_x, eng_e, eng_a, eng_ch,
    input  res_valid, res_ch, res_sample,
    input  timeout_err
  );
endinterface

// File: rtl/anc_engine_arbiter.sv
// Round-robin arbiter sharing one ANC FIR/LMS engine between NCH channels,
// with one-entry sample buffers, tagged results and a job timeout.
module anc_engine_arbiter #(
  parameter int NCH     = 2,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1023
) (
  input logic                clk,
  input logic                rst,
  anc_engine_arbiter_if.slave bus
);
  localparam int CW = $clog2(NCH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, BUSY, DONE
  } state_t;

  state_t          state, state_nx;
  logic [NCH-1:0]  pend;
  logic [DW-1:0]   bx [NCH];
  logic [DW-1:0]   be [NCH];
  logic [DW-1:0]   ba [NCH];
  logic [CW-1:0]   rr;
  logic [CW-1:0]   pick;
  logic [CW-1:0]   idx;
  logic            has_pick;
  logic [CW-1:0]   eng_ch;
  logic [DW-1:0]   eng_x;
  logic [DW-1:0]   eng_e;
  logic [DW-1:0]   eng_a;
  logic [CW-1:0]   res_ch;
  logic [DW-1:0]   res_sample;
  logic [TW-1:0]   cnt;
  logic            tmo_err;
  logic            hit_done;
  logic            hit_tmo;

  // Nearest pending channel after rr; the smallest offset wins.
  always_comb begin
    pick     = '0;
    has_pick = 1'b0;
    idx      = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = CW'((int'(rr) + k) % NCH);
      if (pend[idx]) begin
        pick     = idx;
        has_pick = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    hit_done = 1'b0;
    hit_tmo  = 1'b0;
    unique case (state)
      IDLE:  if (has_pick) state_nx = ISSUE;
      ISSUE: state_nx = BUSY;
      BUSY: begin
        if (bus.eng_done) begin
          hit_done = 1'b1;
          state_nx = DONE;
        end else if (cnt == TW'(TIMEOUT - 1)) begin
          hit_tmo  = 1'b1;
          state_nx = IDLE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= CW'(NCH - 1);
      eng_ch     <= '0;
      eng_x      <= '0;
      eng_e      <= '0;
      eng_a      <= '0;
      res_ch     <= '0;
      res_sample <= '0;
      cnt        <= '0;
      tmo_err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && has_pick) begin
        rr     <= pick;
        eng_ch <= pick;
        eng_x  <= bx[pick];
        eng_e  <= be[pick];
        eng_a  <= ba[pick];
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == BUSY && !hit_done && !hit_tmo) begin
        cnt <= cnt + TW'(1);
      end
      if (hit_done) begin
        res_ch     <= eng_ch;
        res_sample <= bus.eng_out;
      end
      // A new timeout outranks a coincident clear.
      if (hit_tmo) begin
        tmo_err <= 1'b1;
      end else if (bus.err_clr) begin
        tmo_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      for (int i = 0; i < NCH; i++) begin
        bx[i] <= '0;
        be[i] <= '0;
        ba[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if ((hit_done || hit_tmo) && eng_ch == CW'(i)) begin
          pend[i] <= 1'b0;
        end else if (bus.ch_valid[i] && !pend[i]) begin
          pend[i] <= 1'b1;
          bx[i]   <= bus.ch_x[i*DW +: DW];
          be[i]   <= bus.ch_e[i*DW +: DW];
          ba[i]   <= bus.ch_a[i*DW +: DW];
        end
      end
    end
  end

  assign bus.ch_ready    = ~pend;
  assign bus.eng_go      = (state == ISSUE);
  assign bus.eng_x       = eng_x;
  assign bus.eng_e       = eng_e;
  assign bus.eng_a       = eng_a;
  assign bus.eng_ch      = eng_ch;
  assign bus.res_valid   = (state == DONE);
  assign bus.res_ch      = res_ch;
  assign bus.res_sample  = res_sample;
  assign bus.timeout_err = tmo_err;
endmodule

// File: tb/tb_anc_engine_arbiter.sv
// Directed bench for anc_engine_arbiter: job-level reference model checked
// every cycle, plus hand-computed expectations per scenario.
module tb_anc_engine_arbiter;
  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  anc_engine_arbiter_if #(.NCH(NCH), .DW(DW)) bus ();

  anc_engine_arbiter #(
    .NCH(NCH), .DW(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model: a job is granted, spends one cycle issuing, then
  // waits in the engine for done or TMO cycles; a result shows for one cycle.
  logic [NCH-1:0] m_pend;
  logic [DW-1:0]  m_bx [NCH];
  logic [DW-1:0]  m_be [NCH];
  logic [DW-1:0]  m_ba [NCH];
  int             m_rr, m_ch, m_age, m_rch;
  bit             m_job, m_res, m_terr;
  logic [DW-1:0]  m_x, m_e, m_a, m_rs;

  always @(posedge clk or posedge rst) begin : model
    int g, j;
    bit fin, tmo;
    if (rst) begin
      m_pend <= '0;
      for (int i = 0; i < NCH; i++) begin
        m_bx[i] <= '0; m_be[i] <= '0; m_ba[i] <= '0;
      end
      m_rr <= NCH - 1; m_ch <= 0; m_age <= 0; m_rch <= 0;
      m_job <= 0; m_res <= 0; m_terr <= 0;
      m_x <= '0; m_e <= '0; m_a <= '0; m_rs <= '0;
    end else begin
      fin = 0; tmo = 0; g = -1;
      m_res <= 1'b0;
      if (m_job) begin
        if (m_age == 0) begin
          m_age <= 1;
        end else if (bus.eng_done) begin
          m_job <= 0; m_res <= 1; fin = 1;
          m_rch <= m_ch; m_rs <= bus.eng_out;
        end else if (m_age == TMO) begin
          m_job <= 0; fin = 1; tmo = 1;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (!m_res) begin
        for (int k = 1; k <= NCH; k++) begin
          j = (m_rr + k) % NCH;
          if (g < 0 && m_pend[j]) g = j;
        end
        if (g >= 0) begin
          m_job <= 1; m_age <= 0; m_ch <= g; m_rr <= g;
          m_x <= m_bx[g]; m_e <= m_be[g]; m_a <= m_ba[g];
        end
      end
      m_terr <= tmo ? 1'b1 : (bus.err_clr ? 1'b0 : m_terr);
      for (int i = 0; i < NCH; i++) begin
        if (fin && i == m_ch) begin
          m_pend[i] <= 1'b0;
        end else if (bus.ch_valid[i] && !m_pend[i]) begin
          m_pend[i] <= 1'b1;
          m_bx[i] <= bus.ch_x[i*DW +: DW];
          m_be[i] <= bus.ch_e[i*DW +: DW];
          m_ba[i] <= bus.ch_a[i*DW +: DW];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ch_ready", 32'(bus.ch_ready), 32'({~m_pend}));
      chk("eng_go", 32'(bus.eng_go), 32'(m_job && m_age == 0));
      chk("eng_ch", 32'(bus.eng_ch), 32'(m_ch));
      chk("eng_x", 32'(bus.eng_x), 32'(m_x));
      chk("eng_e", 32'(bus.eng_e), 32'(m_e));
      chk("eng_a", 32'(bus.eng_a), 32'(m_a));
      chk("res_valid", 32'(bus.res_valid), 32'(m_res));
      chk("res_ch", 32'(bus.res_ch), 32'(m_rch));
      chk("res_sample", 32'(bus.res_sample), 32'(m_rs));
      chk("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
    end
  end

  // Engine stand-in and bookkeeping, all driven from the main sequence.
  int            cyc = 0;
  bit            eng_auto = 0;
  int            eng_lat = 1;
  logic [DW-1:0] eng_val = '0;
  int            eng_cnt = 0;
  bit            stray = 0;
  bit            stray_go = 0;
  bit            rr_mon = 0;
  int            last_go = -1;
  int            res_cnt = 0;
  int            gq [$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.eng_done = 1'b0;
    if (stray) begin
      bus.eng_done = 1'b1;
      stray = 0;
    end
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        bus.eng_done = 1'b1;
        bus.eng_out  = eng_val;
      end
    end
    if (bus.eng_go) begin
      if (eng_auto) eng_cnt = eng_lat;
      if (stray_go) begin
        bus.eng_done = 1'b1;
        stray_go = 0;
      end
      if (rr_mon) begin
        gq.push_back(int'(bus.eng_ch));
        if (last_go >= 0)
          chk("go_spacing", 32'((cyc - last_go) >= 4), 1);
        last_go = cyc;
      end
    end
    if (bus.res_valid) res_cnt++;
  endtask

  task automatic set_ch(input int i, input logic [DW-1:0] x,
                        input logic [DW-1:0] e, input logic [DW-1:0] a);
    bus.ch_x[i*DW +: DW] = x;
    bus.ch_e[i*DW +: DW] = e;
    bus.ch_a[i*DW +: DW] = a;
  endtask

  task automatic do_reset();
    bus.ch_valid = '0;
    bus.eng_done = 1'b0;
    bus.err_clr  = 1'b0;
    stray = 0; stray_go = 0; eng_cnt = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_go(input int lim, output int n);
    n = 0;
    while (!bus.eng_go && n < lim) begin
      tick();
      n++;
    end
    chk("go_seen", 32'(bus.eng_go), 1);
  endtask

  task automatic wait_res(input int lim, output int n);
    n = 0;
    while (!bus.res_valid && n < lim) begin
      tick();
      n++;
    end
    chk("res_seen", 32'(bus.res_valid), 1);
  endtask

  initial begin : main
    int n, r0;
    bus.ch_valid = '0;
    bus.ch_x = '0; bus.ch_e = '0; bus.ch_a = '0;
    bus.eng_done = 1'b0;
    bus.eng_out  = '0;
    bus.err_clr  = 1'b0;

    do_reset();
    chk_en = 1;
    chk("rst_ready", 32'(bus.ch_ready), 32'h3);
    chk("rst_go", 32'(bus.eng_go), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_terr", 32'(bus.timeout_err), 0);
    chk("rst_eng_x", 32'(bus.eng_x), 0);
    chk("rst_res_sample", 32'(bus.res_sample), 0);

    // Single job on channel 0, engine latency 5.
    eng_auto = 1; eng_lat = 5; eng_val = 16'h1234;
    set_ch(0, 16'h0100, 16'hFF00, 16'h0010);
    bus.ch_valid = 2'b01;
    tick();
    bus.ch_valid = 2'b00;
    wait_go(10, n);
    chk("go_latency", 32'(n + 1), 2);
    chk("sj_eng_x", 32'(bus.eng_x), 32'h0100);
    chk("sj_eng_e", 32'(bus.eng_e), 32'hFF00);
    chk("sj_eng_a", 32'(bus.eng_a), 32'h0010);
    chk("sj_eng_ch", 32'(bus.eng_ch), 0);
    wait_res(20, n);
    chk("sj_res_latency", 32'(n), 6);
    chk("sj_res_ch", 32'(bus.res_ch), 0);
    chk("sj_res_sample", 32'(bus.res_sample), 32'h1234);
    chk("sj_ready_done", 32'(bus.ch_ready[0]), 1);
    repeat (3) tick();

    // Round robin with both channels always pending.
    do_reset();
    eng_auto = 1; eng_lat = 3; eng_val = 16'h0ABC;
    set_ch(0, 16'hAAAA, 16'h0001, 16'h0002);
    set_ch(1, 16'h5555, 16'h0003, 16'h0004);
    gq.delete();
    last_go = -1;
    rr_mon = 1;
    bus.ch_valid = 2'b11;
    n = 0;
    while (gq.size() < 4 && n < 80) begin
      tick();
      n++;
    end
    bus.ch_valid = 2'b00;
    rr_mon = 0;
    chk("rr_jobs", 32'(gq.size()), 4);
    if (gq.size() == 4) begin
      chk("rr_g0", 32'(gq[0]), 0);
      chk("rr_g1", 32'(gq[1]), 1);
      chk("rr_g2", 32'(gq[2]), 0);
      chk("rr_g3", 32'(gq[3]), 1);
    end
    repeat (30) tick();

    // Backpressure: a sample offered while channel 1 is full is dropped.
    do_reset();
    eng_auto = 1; eng_lat = 4; eng_val = 16'h0BAD;
    set_ch(1, 16'h1111, 16'h0000, 16'h0000);
    bus.ch_valid = 2'b10;
    tick();
    set_ch(1, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    tick();
    chk("bp_ready1", 32'(bus.ch_ready[1]), 0);
    tick();
    bus.ch_valid = 2'b00;
    chk("bp_first_x", 32'(bus.eng_x), 32'h1111);
    wait_res(20, n);
    chk("bp_res_ch", 32'(bus.res_ch), 1);
    set_ch(1, 16'h0001, 16'h0002, 16'h0003);
    bus.ch_valid = 2'b10;
    tick();
    bus.ch_valid = 2'b00;
    wait_go(10, n);
    chk("bp_second_x", 32'(bus.eng_x), 32'h0001);
    chk("bp_second_ch", 32'(bus.eng_ch), 1);
    wait_res(20, n);
    repeat (2) tick();

    // Timeout: engine silent.
    do_reset();
    eng_auto = 0;
    set_ch(0, 16'h0042, 16'h0000, 16'h0000);
    bus.ch_valid = 2'b01;
    tick();
    bus.ch_valid = 2'b00;
    wait_go(10, n);
    tick();
    r0 = res_cnt;
    n = 0;
    while (!bus.timeout_err && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 16);
    chk("to_flag", 32'(bus.timeout_err), 1);
    chk("to_no_result", 32'(res_cnt - r0), 0);
    chk("to_pend_clear", 32'(bus.ch_ready), 32'h3);
    repeat (2) tick();
    chk("to_idle_go", 32'(bus.eng_go), 0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("to_clear", 32'(bus.timeout_err), 0);
    set_ch(1, 16'h0077, 16'h0000, 16'h0000);
    bus.ch_valid = 2'b10;
    tick();
    bus.ch_valid = 2'b00;
    wait_go(10, n);
    tick();
    repeat (15) tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("to_set_wins", 32'(bus.timeout_err), 1);
    repeat (2) tick();

    // Stray done pulses in IDLE and ISSUE are ignored.
    do_reset();
    eng_auto = 1; eng_lat = 3; eng_val = 16'h00C3;
    r0 = res_cnt;
    stray = 1;
    repeat (3) tick();
    chk("stray_idle", 32'(res_cnt - r0), 0);
    set_ch(0, 16'h0005, 16'h0006, 16'h0007);
    stray_go = 1;
    bus.ch_valid = 2'b01;
    tick();
    bus.ch_valid = 2'b00;
    wait_go(10, n);
    repeat (12) tick();
    chk("stray_one_result", 32'(res_cnt - r0), 1);
    chk("stray_sample", 32'(bus.res_sample), 32'h00C3);

    // Asynchronous reset while channel 1's job is in the engine.
    do_reset();
    eng_auto = 0;
    set_ch(1, 16'h2222, 16'h3333, 16'h4444);
    bus.ch_valid = 2'b10;
    tick();
    bus.ch_valid = 2'b00;
    wait_go(10, n);
    repeat (3) tick();
    chk("mid_busy_x", 32'(bus.eng_x), 32'h2222);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_ready", 32'(bus.ch_ready), 32'h3);
    chk("ar_go", 32'(bus.eng_go), 0);
    chk("ar_eng_x", 32'(bus.eng_x), 0);
    chk("ar_eng_ch", 32'(bus.eng_ch), 0);
    chk("ar_res_valid", 32'(bus.res_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    r0 = res_cnt;
    stray = 1;
    repeat (3) tick();
    chk("ar_late_done", 32'(res_cnt - r0), 0);
    chk("ar_ready_after", 32'(bus.ch_ready), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/anc_engine_arbiter.md
Name: anc_engine_arbiter

Overview:
- Time-multiplexes one shared ANC FIR/LMS engine, driven through a go/done handshake, between NCH independent sample channels (e.g. left/right ear paths).
- Each channel gets a one-entry holding buffer for its (x, e, a) sample triple.
- A round-robin FSM issues one job at a time to the engine, returns each result tagged with its channel, and aborts any job whose done never arrives.

Parameters:
- NCH, 2, number of requesting channels (2..8).
- DW, 16, sample width, signed two's complement.
- TIMEOUT, 1023, maximum BUSY cycles to wait for eng_done before aborting the job.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- ch_valid  in  NCH  per-channel sample valid.
- ch_ready  out  NCH  per-channel buffer empty.
- ch_x  in  NCH*DW  packed reference samples; channel i occupies bits [i*DW +: DW].
- ch_e  in  NCH*DW  packed error samples.
- ch_a  in  NCH*DW  packed desired samples.
- eng_go  out  1  single-cycle engine start pulse.
- eng_x, eng_e, eng_a  out  DW each  operands for the granted channel.
- eng_ch  out  clog2(NCH)  granted channel index.
- eng_done  in  1  engine completion pulse.
- eng_out  in  DW  engine result, valid while eng_done=1.
- res_valid  out  1  single-cycle result strobe.
- res_ch  out  clog2(NCH)  channel index of the result.
- res_sample  out  DW  result sample.
- timeout_err  out  1  sticky abort flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (asynchronous, active-high) drives the block to its idle state:
  - all pend bits = 0, so ch_ready = all ones;
  - state = IDLE, rr pointer = NCH-1 (channel 0 wins first);
  - eng_go = 0, eng_x, eng_e, eng_a = 0, eng_ch = 0;
  - res_valid = 0, res_ch = 0, res_sample = 0;
  - timeout_err = 0, timeout counter = 0.
  - Reset mid-job discards the job and all buffered samples; a late eng_done after reset is ignored because the state is IDLE.
- Buffer:
  - ch_ready[i] = ~pend[i], combinational from the register.
  - On a clk edge with ch_valid[i] & ch_ready[i], latch channel i's slices and set pend[i].
  - ch_valid while pend[i]=1 is ignored; the sample is dropped and the upstream side must hold it.
- Grant is evaluated on the registered pend only. A sample accepted at edge t is eligible at edge t+1 at the earliest.
- FSM states and transitions:
  - IDLE: if any pend, pick the first pending channel after rr (modulo NCH) and set rr and eng_ch to it, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: eng_go=1 for exactly one cycle, with eng_x/e/a driven from the granted buffer. Clear the timeout counter and go to BUSY.
  - BUSY: eng_x/e/a/eng_ch are held stable.
    - If eng_done=1: capture eng_out into res_sample and eng_ch into res_ch, clear pend[eng_ch], go to DONE.
    - Else if counter == TIMEOUT-1: clear pend[eng_ch], set timeout_err, go to IDLE with no result.
    - Else increment the counter.
  - DONE: res_valid=1 for one cycle, then go to IDLE.
- eng_done is sampled only in BUSY; a pulse in IDLE, ISSUE or DONE is ignored.
- Minimum job period is 4 cycles plus engine latency.
- A channel whose pend clears at the BUSY->DONE edge can be re-accepted on that same edge+1. Channel i's ready reasserts in DONE.
- Fairness: with all channels continuously pending, grants rotate 0,1,...,NCH-1,0. No channel waits more than NCH-1 jobs.
- timeout_err: err_clr clears it. If err_clr and a new timeout fall on the same edge, set wins.
- Data paths are pure muxing with no arithmetic and no width change.

Test Plan:
- Single job: reset, then ch_valid[0] with x=0x0100, e=0xFF00, a=0x0010. Expect eng_go 2 edges after acceptance, with eng_x=0x0100 and eng_ch=0. Engine returns done + eng_out=0x1234 after 5 cycles. Expect res_valid one cycle later with res_ch=0 and res_sample=0x1234; ch_ready[0] high in DONE.
- Round robin: both channels held pending continuously, engine latency 3. Expect grant order 0,1,0,1 and exactly one eng_go per job, never two eng_go within 4 cycles.
- Backpressure: a second ch_valid[1] sample 0x7FFF while pend[1]=1 is dropped. After the job completes, eng_x on channel 1's next job equals the later re-presented 0x0001, not 0x7FFF.
- Timeout: engine never asserts done, TIMEOUT=16. Expect timeout_err to rise 16 cycles after BUSY entry, no res_valid, pend cleared, FSM back in IDLE. Then assert err_clr: flag clears. err_clr coincident with a second timeout leaves the flag at 1.
- Stray done: an eng_done pulse in IDLE and in ISSUE produces no res_valid. The real done in BUSY still produces exactly one result.
- Reset mid-BUSY: assert rst while channel 1's job is outstanding. All outputs return to reset values immediately (asynchronous). A following eng_done produces no res_valid, and ch_ready = all ones.
